// File: rtl/timer_unit_pkg.sv
// Shared definitions for the timer peripheral.
// Holds the tmr_ctrl field positions and the state encodings that the register file also uses.
package timer_unit_pkg;

    localparam int unsigned TmrEn     = 0;
    localparam int unsigned TmrMode   = 1;
    localparam int unsigned TmrOvfClr = 2;
    localparam int unsigned TmrRsvd   = 3;
    localparam int unsigned TmrPsLo   = 4;
    localparam int unsigned TmrPsHi   = 7;
    localparam int unsigned TmrTopLo  = 16;
    localparam int unsigned TmrTopHi  = 31;

    typedef enum logic [1:0] {
        TmrIdle = 2'd0,
        TmrRun  = 2'd1,
        TmrDone = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/tmr_prescaler.sv
// Power-of-two prescaler: produces a tick every 2^ps cycles while run_i is high.
// The count restarts from zero whenever run_i is low or ps_i changes.
module tmr_prescaler #(
    parameter int unsigned PS_W = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            run_i,
    input  logic [PS_W-1:0] ps_i,
    output logic            tick_o
);

    localparam int unsigned CntW = (1 << PS_W) - 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] limit;
    logic [PS_W-1:0] ps_q;
    logic            ps_chg;

    // 2^ps - 1; for the largest ps the shift overflows to zero and the subtract gives all ones.
    assign limit  = (CntW'(1) << ps_i) - CntW'(1);
    assign ps_chg = (ps_i != ps_q);
    assign tick_o = run_i && !ps_chg && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (!run_i || ps_chg || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            ps_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ps_q  <= ps_i;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Timer peripheral: prescaled up-counter with programmable TOP, periodic or one-shot mode,
// a sticky overflow flag and a one-cycle overflow strobe. All outputs are registered.
module timer_unit
    import timer_unit_pkg::*;
#(
    parameter int unsigned CNTR_W = 16,
    parameter int unsigned PS_W   = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [31:0]       tmr_ctrl_i,
    output logic [CNTR_W-1:0] tmr_cntr_o,
    output logic              tmr_overflow_o,
    output logic              tmr_ovf_pulse_o
);

    tmr_state_e        state_q;
    logic [CNTR_W-1:0] cntr_q;
    logic              ovf_q;
    logic              pulse_q;

    logic              en;
    logic              mode;
    logic              ovf_clr;
    logic [PS_W-1:0]   ps;
    logic [CNTR_W-1:0] top;
    logic              tick;
    logic              ctrl_unused;

    assign en      = tmr_ctrl_i[TmrEn];
    assign mode    = tmr_ctrl_i[TmrMode];
    assign ovf_clr = tmr_ctrl_i[TmrOvfClr];
    assign ps      = tmr_ctrl_i[TmrPsLo +: PS_W];
    assign top     = CNTR_W'(tmr_ctrl_i[TmrTopHi:TmrTopLo]);

    assign ctrl_unused = ^{tmr_ctrl_i[TmrRsvd], tmr_ctrl_i[TmrTopLo-1:TmrPsHi+1]};

    tmr_prescaler #(
        .PS_W (PS_W)
    ) u_prescaler (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .run_i   (state_q == TmrRun),
        .ps_i    (ps),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= TmrIdle;
            cntr_q  <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            // A clear is overridden below by a same-cycle overflow, so no event is lost.
            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
            case (state_q)
                TmrIdle: begin
                    if (en) begin
                        state_q <= TmrRun;
                    end
                end
                TmrRun: begin
                    if (!en) begin
                        state_q <= TmrIdle;
                    end else if (tick) begin
                        if (cntr_q == top) begin
                            cntr_q  <= '0;
                            pulse_q <= 1'b1;
                            ovf_q   <= 1'b1;
                            if (mode) begin
                                state_q <= TmrDone;
                            end
                        end else begin
                            // Wraps silently past the maximum when TOP was lowered below the count.
                            cntr_q <= cntr_q + CNTR_W'(1);
                        end
                    end
                end
                TmrDone: begin
                    cntr_q <= '0;
                    if (!en) begin
                        state_q <= TmrIdle;
                    end
                end
                default: begin
                    state_q <= TmrIdle;
                end
            endcase
        end
    end

    assign tmr_cntr_o      = cntr_q;
    assign tmr_overflow_o  = ovf_q;
    assign tmr_ovf_pulse_o = pulse_q;

endmodule

// File: doc/timer_unit.md
Name: timer_unit

Overview:
- Memory-mapped timer peripheral: the far end of the processor's timer interface.
- The register file drives tmr_ctrl; this block consumes it and returns tmr_cntr and tmr_overflow, which software reads back through the register file.
- Provides a prescaled up-counter with programmable TOP, periodic or one-shot mode, and a sticky overflow flag.

Parameters:
- CNTR_W, 16, counter width; must equal tmr_cntr width seen by the register file.
- PS_W, 4, prescaler-select field width; divide ratio is 2^PS, so 1 to 32768.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tmr_ctrl  in  32  control word from the register file.
- tmr_cntr  out  CNTR_W  current count value.
- tmr_overflow  out  1  sticky overflow flag.
- tmr_ovf_pulse  out  1  one-cycle strobe per overflow event.

Behaviour:
- Control fields in tmr_ctrl:
  - [0] EN
  - [1] MODE: 0 = periodic, 1 = one-shot
  - [2] OVF_CLR: level-sensitive clear
  - [3] reserved, ignored
  - [7:4] PS
  - [15:8] reserved, ignored
  - [31:16] TOP
- tmr_ctrl is sampled every clk edge, with no extra latency. A software write reaches tmr_ctrl one edge after the store; the timer reacts on the following edge.
- Reset (async, takes effect immediately): state = IDLE, prescaler count = 0, tmr_cntr = 0, tmr_overflow = 0, tmr_ovf_pulse = 0.
- Reset asserted mid-count discards all progress. No state survives reset.
- Prescaler:
  - Counts clk edges while state = RUN.
  - Asserts tick when its count == 2^PS - 1, then wraps to 0.
  - PS = 0 gives a tick every cycle.
  - Any change of PS, or any cycle outside RUN, clears the prescaler count to 0. No partial period carries over.
- State machine (3 states):
  - IDLE: tmr_cntr holds its value (pause). EN = 1 -> RUN.
  - RUN:
    - EN = 0 -> IDLE; count is held.
    - On tick with tmr_cntr != TOP: tmr_cntr increments by 1.
    - On tick with tmr_cntr == TOP: overflow event, and tmr_cntr <= 0. MODE = 0 stays in RUN; MODE = 1 -> DONE.
  - DONE: tmr_cntr = 0 and held; no events. EN = 0 -> IDLE.
- Counting is unsigned modulo (TOP + 1).
- TOP = 0: every tick is an overflow; tmr_cntr stays 0.
- TOP lowered below the current count while running: counting continues up to 2^CNTR_W - 1, wraps to 0 with no overflow event, then reaches the new TOP normally.
- Overflow event:
  - tmr_ovf_pulse = 1 for exactly one cycle on the edge after the tick.
  - tmr_overflow set to 1 on the same edge.
- OVF_CLR = 1 clears tmr_overflow on each edge. If an overflow event and OVF_CLR coincide, set wins, so no event is lost.
- MODE change while in RUN takes effect at the next overflow.
- EN and overflow in the same cycle: EN = 0 wins. The state goes to IDLE, tmr_cntr holds its value, and no event is raised.
- Outputs are registered; there is no combinational path from tmr_ctrl to any output.

Decomposition:
- Shared include file ./include/timer.v, alongside registers.v, holds:
  - field position defines: TMR_EN, TMR_MODE, TMR_OVF_CLR, TMR_PS_LO/HI, TMR_TOP_LO/HI
  - state encodings: TMR_IDLE = 2'd0, TMR_RUN = 2'd1, TMR_DONE = 2'd2
- The register file and software tests include the same file.
- One sub-module: tmr_prescaler.
  - Inputs: clk, reset, run, ps.
  - Output: tick.
  - Handles the 2^PS compare and the clear on PS change.
- The FSM, counter and flag stay in timer_unit.

Test Plan:
- Periodic, PS=0, TOP=3, EN=1 -> tmr_cntr sequence 0,1,2,3,0,1; tmr_ovf_pulse high one cycle after each 3; tmr_overflow stays 1.
- PS=2, TOP=1 -> tmr_cntr increments every 4 cycles; first overflow pulse 8 cycles after RUN entry; changing PS to 0 mid-run restarts the prescaler, and the next increment follows 1 cycle later.
- One-shot, PS=0, TOP=5 -> single pulse, state DONE, tmr_cntr held at 0 for 20 cycles; EN=0 then EN=1 -> a new run produces exactly one more pulse.
- Overflow coincident with OVF_CLR=1 -> tmr_overflow = 1 after the edge; OVF_CLR held one more cycle with no event -> tmr_overflow = 0.
- EN dropped at tmr_cntr=7 (TOP=10) -> tmr_cntr holds 7 for 10 cycles; EN=1 -> resumes at 8, and the overflow occurs after 10.
- Reset asserted asynchronously mid-run at tmr_cntr=4 -> all outputs 0 immediately; after release with EN=1, counting restarts from 0.
